cmd_cfg_mc: RTL and testbench

//  Parametrised command/config unit for the logic analyser, successor to the fixed 5-channel unit.

---
 rtl/cmd_cfg_pkg.sv | 53 +++++
 rtl/cfg_regfile.sv | 104 ++++++++++
 rtl/cmd_cfg_mc.sv | 143 ++++++++++++++
 tb/tb_cmd_cfg_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_cfg_pkg.sv
// Shared types and constants for the logic-analyser command/config unit.
// Holds the FSM states, opcodes, register map, response codes and reset values.
package cmd_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESP_WAIT,
        DUMP_ADDR,
        DUMP_RD,
        DUMP_SEND
    } state_t;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    localparam logic [4:0] A_TRIG = 5'h00;
    localparam logic [4:0] A_CH1  = 5'h01;
    localparam logic [4:0] A_CH5  = 5'h05;
    localparam logic [4:0] A_DEC  = 5'h06;
    localparam logic [4:0] A_VIH  = 5'h07;
    localparam logic [4:0] A_VIL  = 5'h08;
    localparam logic [4:0] A_MTH  = 5'h09;
    localparam logic [4:0] A_MTL  = 5'h0A;
    localparam logic [4:0] A_MSH  = 5'h0B;
    localparam logic [4:0] A_MSL  = 5'h0C;
    localparam logic [4:0] A_BDH  = 5'h0D;
    localparam logic [4:0] A_BDL  = 5'h0E;
    localparam logic [4:0] A_TPH  = 5'h0F;
    localparam logic [4:0] A_TPL  = 5'h10;
    localparam logic [4:0] A_CH6  = 5'h11;
    localparam logic [4:0] A_CH8  = 5'h13;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [5:0] TRIG_RST = 6'h03;
    localparam logic [4:0] CH_RST   = 5'h01;
    localparam logic [7:0] VIH_RST  = 8'hAA;
    localparam logic [7:0] VIL_RST  = 8'h55;
    localparam logic [7:0] BDH_RST  = 8'h06;
    localparam logic [7:0] BDL_RST  = 8'hC8;
    localparam logic [7:0] TPL_RST  = 8'h01;

    // Channel number (1..8) for a channel-config address, 0 for anything else.
    function automatic logic [3:0] ch_of_addr(input logic [4:0] a);
        if (a >= A_CH1 && a <= A_CH5) return a[3:0];
        if (a >= A_CH6 && a <= A_CH8) return 4'(a - 5'd11);
        return 4'd0;
    endfunction

endpackage

// File: rtl/cfg_regfile.sv
// Configuration register file: register flops, write decode, read mux and
// address-valid flag for NUM_CH channels.
module cfg_regfile
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            addr,
    input  logic [7:0]            wdata,
    input  logic                  set_capture_done,
    output logic [7:0]            rd_data,
    output logic                  addr_ok,
    output logic [5:0]            TrigCfg,
    output logic [NUM_CH*5-1:0]   ch_trig_cfg,
    output logic [3:0]            decimator,
    output logic [7:0]            VIH,
    output logic [7:0]            VIL,
    output logic [7:0]            matchH,
    output logic [7:0]            matchL,
    output logic [7:0]            maskH,
    output logic [7:0]            maskL,
    output logic [7:0]            baud_cntH,
    output logic [7:0]            baud_cntL,
    output logic [LOG2-1:0]       trig_pos
);

    localparam int HW = LOG2 - 8;

    logic [NUM_CH-1:0][4:0] ch_cfg;
    logic [HW-1:0]          trig_posH;
    logic [7:0]             trig_posL;
    logic [3:0]             ch;

    assign ch          = ch_of_addr(addr);
    assign ch_trig_cfg = ch_cfg;
    assign trig_pos    = {trig_posH, trig_posL};
    assign addr_ok     = (ch != 4'd0) ? (int'(ch) <= NUM_CH) : (addr <= A_TPL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            TrigCfg   <= TRIG_RST;
            ch_cfg    <= {NUM_CH{CH_RST}};
            decimator <= 4'h0;
            VIH       <= VIH_RST;
            VIL       <= VIL_RST;
            matchH    <= 8'h00;
            matchL    <= 8'h00;
            maskH     <= 8'h00;
            maskL     <= 8'h00;
            baud_cntH <= BDH_RST;
            baud_cntL <= BDL_RST;
            trig_posH <= '0;
            trig_posL <= TPL_RST;
        end else begin
            // The later write assignment overrides the capture-done flag.
            if (set_capture_done) TrigCfg[4] <= 1'b1;
            if (we) begin
                case (addr)
                    A_TRIG: TrigCfg   <= wdata[5:0];
                    A_DEC:  decimator <= wdata[3:0];
                    A_VIH:  VIH       <= wdata;
                    A_VIL:  VIL       <= wdata;
                    A_MTH:  matchH    <= wdata;
                    A_MTL:  matchL    <= wdata;
                    A_MSH:  maskH     <= wdata;
                    A_MSL:  maskL     <= wdata;
                    A_BDH:  baud_cntH <= wdata;
                    A_BDL:  baud_cntL <= wdata;
                    A_TPH:  trig_posH <= wdata[HW-1:0];
                    A_TPL:  trig_posL <= wdata;
                    default: ;
                endcase
                for (int i = 0; i < NUM_CH; i++)
                    if (ch == 4'(i + 1)) ch_cfg[i] <= wdata[4:0];
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            A_TRIG: rd_data = {2'b00, TrigCfg};
            A_DEC:  rd_data = {4'h0, decimator};
            A_VIH:  rd_data = VIH;
            A_VIL:  rd_data = VIL;
            A_MTH:  rd_data = matchH;
            A_MTL:  rd_data = matchL;
            A_MSH:  rd_data = maskH;
            A_MSL:  rd_data = maskL;
            A_BDH:  rd_data = baud_cntH;
            A_BDL:  rd_data = baud_cntL;
            A_TPH:  rd_data = 8'(trig_posH);
            A_TPL:  rd_data = trig_posL;
            default:
                for (int i = 0; i < NUM_CH; i++)
                    if (ch == 4'(i + 1)) rd_data = {3'b000, ch_cfg[i]};
        endcase
    end

endmodule

// File: rtl/cmd_cfg_mc.sv
// Command/config unit top: host command FSM, channel dump sequencer and
// response register around the configuration register file.
module cmd_cfg_mc
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cmd,
    input  logic                  cmd_rdy,
    input  logic                  resp_sent,
    input  logic                  set_capture_done,
    input  logic [LOG2-1:0]       waddr,
    input  logic [NUM_CH*8-1:0]   rdata,
    output logic [7:0]            resp,
    output logic                  send_resp,
    output logic                  clr_cmd_rdy,
    output logic [LOG2-1:0]       raddr,
    output logic                  dump_busy,
    output logic [LOG2-1:0]       trig_pos,
    output logic [3:0]            decimator,
    output logic [7:0]            maskH,
    output logic [7:0]            maskL,
    output logic [7:0]            matchH,
    output logic [7:0]            matchL,
    output logic [7:0]            baud_cntH,
    output logic [7:0]            baud_cntL,
    output logic [5:0]            TrigCfg,
    output logic [NUM_CH*5-1:0]   ch_trig_cfg,
    output logic [7:0]            VIH,
    output logic [7:0]            VIL
);

    localparam logic [LOG2:0]   CNT_END = (LOG2 + 1)'(ENTRIES);
    localparam logic [LOG2-1:0] LAST    = LOG2'(ENTRIES - 1);

    state_t          state;
    logic [LOG2:0]   cnt;
    logic [2:0]      dump_ch;
    logic [1:0]      op;
    logic [4:0]      addr;
    logic [2:0]      dch;
    logic            accept, dump_ok, we, addr_ok;
    logic [7:0]      rd_data, rbyte;

    assign op      = cmd[15:14];
    assign addr    = cmd[12:8];
    assign dch     = cmd[10:8];
    // clr_cmd_rdy high means the host has not yet dropped the finished command.
    assign accept  = (state == IDLE) && cmd_rdy && !clr_cmd_rdy;
    assign dump_ok = (dch != 3'd0) && (int'(dch) <= NUM_CH);
    assign we      = accept && (op == OP_WR) && addr_ok;

    always_comb begin
        rbyte = 8'h00;
        for (int i = 0; i < NUM_CH; i++)
            if (dump_ch == 3'(i + 1)) rbyte = rdata[8*i +: 8];
    end

    cfg_regfile #(.NUM_CH(NUM_CH), .LOG2(LOG2)) u_regs (
        .clk              (clk),
        .rst              (rst),
        .we               (we),
        .addr             (addr),
        .wdata            (cmd[7:0]),
        .set_capture_done (set_capture_done),
        .rd_data          (rd_data),
        .addr_ok          (addr_ok),
        .TrigCfg          (TrigCfg),
        .ch_trig_cfg      (ch_trig_cfg),
        .decimator        (decimator),
        .VIH              (VIH),
        .VIL              (VIL),
        .matchH           (matchH),
        .matchL           (matchL),
        .maskH            (maskH),
        .maskL            (maskL),
        .baud_cntH        (baud_cntH),
        .baud_cntL        (baud_cntL),
        .trig_pos         (trig_pos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            resp        <= 8'h00;
            send_resp   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            dump_busy   <= 1'b0;
            raddr       <= '0;
            cnt         <= '0;
            dump_ch     <= 3'd0;
        end else begin
            send_resp   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_DUMP && dump_ok) begin
                        raddr     <= waddr;
                        dump_busy <= 1'b1;
                        cnt       <= '0;
                        dump_ch   <= dch;
                        state     <= DUMP_ADDR;
                    end else begin
                        send_resp <= 1'b1;
                        state     <= RESP_WAIT;
                        case (op)
                            OP_RD:   resp <= addr_ok ? rd_data : NAK;
                            OP_WR:   resp <= addr_ok ? ACK : NAK;
                            default: resp <= NAK;
                        endcase
                    end
                end
                RESP_WAIT: if (resp_sent) begin
                    clr_cmd_rdy <= 1'b1;
                    state       <= IDLE;
                end
                DUMP_ADDR: state <= DUMP_RD;
                DUMP_RD: begin
                    resp      <= rbyte;
                    send_resp <= 1'b1;
                    cnt       <= cnt + 1'b1;
                    state     <= DUMP_SEND;
                end
                DUMP_SEND: if (resp_sent) begin
                    if (cnt == CNT_END) begin
                        clr_cmd_rdy <= 1'b1;
                        dump_busy   <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        raddr <= (raddr == LAST) ? '0 : raddr + 1'b1;
                        state <= DUMP_ADDR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Self-checking bench for cmd_cfg_mc: register map model, capture RAM model
// and UART host behaviour driving directed and random commands.
module tb_cmd_cfg_mc;

    localparam int NUM_CH  = 5;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [15:0]          cmd = 16'h0;
    logic                 cmd_rdy = 1'b0;
    logic                 resp_sent = 1'b0;
    logic                 set_capture_done = 1'b0;
    logic [LOG2-1:0]      waddr = '0;
    logic [NUM_CH*8-1:0]  rdata = '0;
    logic [7:0]           resp;
    logic                 send_resp, clr_cmd_rdy, dump_busy;
    logic [LOG2-1:0]      raddr, trig_pos;
    logic [3:0]           decimator;
    logic [7:0]           maskH, maskL, matchH, matchL, baud_cntH, baud_cntL, VIH, VIL;
    logic [5:0]           TrigCfg;
    logic [NUM_CH*5-1:0]  ch_trig_cfg;

    int vectors = 0;
    int miscompares = 0;

    logic [NUM_CH*8-1:0] ram [0:ENTRIES-1];
    logic [7:0] mdl [0:31];
    logic [7:0] msk [0:31];
    logic [7:0] rstv [0:31];
    bit         vld [0:31];

    cmd_cfg_mc #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
        .set_capture_done(set_capture_done), .waddr(waddr), .rdata(rdata),
        .resp(resp), .send_resp(send_resp), .clr_cmd_rdy(clr_cmd_rdy), .raddr(raddr),
        .dump_busy(dump_busy), .trig_pos(trig_pos), .decimator(decimator),
        .maskH(maskH), .maskL(maskL), .matchH(matchH), .matchL(matchL),
        .baud_cntH(baud_cntH), .baud_cntL(baud_cntL), .TrigCfg(TrigCfg),
        .ch_trig_cfg(ch_trig_cfg), .VIH(VIH), .VIL(VIL)
    );

    always #5 clk = ~clk;

    // Capture RAM with one cycle of read latency.
    always @(posedge clk) rdata <= ram[raddr];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register map as a table: address -> width mask, reset value, presence.
    task automatic build_map();
        for (int a = 0; a < 32; a++) begin
            msk[a] = 8'hFF; rstv[a] = 8'h00; vld[a] = (a <= 16);
        end
        msk[0] = 8'h3F; rstv[0] = 8'h03;
        for (int c = 1; c <= 8; c++) begin
            int a;
            a = (c <= 5) ? c : c + 11;
            msk[a] = 8'h1F; rstv[a] = 8'h01; vld[a] = (c <= NUM_CH);
        end
        msk[6] = 8'h0F;
        rstv[7] = 8'hAA; rstv[8] = 8'h55; rstv[13] = 8'h06; rstv[14] = 8'hC8;
        msk[15] = 8'((1 << (LOG2 - 8)) - 1);
        rstv[16] = 8'h01;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) mdl[a] = rstv[a];
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".TrigCfg"},   32'(TrigCfg),   32'(mdl[0]));
        for (int c = 1; c <= NUM_CH; c++)
            chk({tag, ".ch_cfg"}, 32'(ch_trig_cfg[5*(c-1) +: 5]), 32'(mdl[(c <= 5) ? c : c + 11]));
        chk({tag, ".decimator"}, 32'(decimator), 32'(mdl[6]));
        chk({tag, ".VIH"},       32'(VIH),       32'(mdl[7]));
        chk({tag, ".VIL"},       32'(VIL),       32'(mdl[8]));
        chk({tag, ".matchH"},    32'(matchH),    32'(mdl[9]));
        chk({tag, ".matchL"},    32'(matchL),    32'(mdl[10]));
        chk({tag, ".maskH"},     32'(maskH),     32'(mdl[11]));
        chk({tag, ".maskL"},     32'(maskL),     32'(mdl[12]));
        chk({tag, ".baud_cntH"}, 32'(baud_cntH), 32'(mdl[13]));
        chk({tag, ".baud_cntL"}, 32'(baud_cntL), 32'(mdl[14]));
        chk({tag, ".trig_pos"},  32'(trig_pos),  (32'(mdl[15]) * 256 + 32'(mdl[16])) % (1 << LOG2));
    endtask

    task automatic wait_sig(input bit want_send);
        int n;
        n = 0;
        while (!(want_send ? send_resp : clr_cmd_rdy) && n < 30) begin
            @(negedge clk); n++;
        end
    endtask

    // Host side of one read/write/NAK command; scd pulses set_capture_done
    // in the accept cycle.
    task automatic do_cmd(input logic [15:0] c, input bit scd, output logic [7:0] r);
        int extra;
        cmd = c; cmd_rdy = 1'b1; set_capture_done = scd;
        @(negedge clk);
        set_capture_done = 1'b0;
        wait_sig(1'b1);
        chk("send_resp", 32'(send_resp), 32'd1);
        r = resp;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        wait_sig(1'b0);
        chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'd1);
        cmd_rdy = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (clr_cmd_rdy || send_resp) extra++;
        end
        chk("extra_pulses", 32'(extra), 32'd0);
    endtask

    task automatic apply(input logic [15:0] c, input bit scd);
        logic [7:0] r, exp;
        int a, op;
        a = int'(c[12:8]); op = int'(c[15:14]);
        if (op == 0)      exp = vld[a] ? mdl[a] : 8'hEE;
        else if (op == 1) exp = vld[a] ? 8'hA5 : 8'hEE;
        else              exp = 8'hEE;
        do_cmd(c, scd, r);
        chk($sformatf("resp_%04h", c), 32'(r), 32'(exp));
        if (scd) mdl[0] = mdl[0] | 8'h10;
        if (op == 1 && vld[a]) mdl[a] = c[7:0] & msk[a];
    endtask

    // Dump a channel; abort_at >= 0 asserts rst after that byte.
    task automatic do_dump(input int ch, input int wa, input int abort_at);
        int idx, extra;
        waddr = LOG2'(wa);
        cmd = 16'h8000 | 16'(ch << 8); cmd_rdy = 1'b1;
        for (int k = 0; k < ENTRIES; k++) begin
            wait_sig(1'b1);
            if (!send_resp) begin
                chk("dump_send_timeout", 32'(send_resp), 32'd1);
                cmd_rdy = 1'b0;
                return;
            end
            idx = (wa + k) % ENTRIES;
            chk("dump_byte", 32'(resp), 32'(ram[idx][8*(ch-1) +: 8]));
            chk("dump_raddr", 32'(raddr), 32'(idx));
            if (k == 0) chk("dump_busy", 32'(dump_busy), 32'd1);
            if (k == abort_at) begin
                rst = 1'b1; cmd_rdy = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                chk("abort_busy", 32'(dump_busy), 32'd0);
                chk("abort_send", 32'(send_resp), 32'd0);
                chk("abort_raddr", 32'(raddr), 32'd0);
                chk("abort_resp", 32'(resp), 32'd0);
                check_regs("abort");
                return;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            resp_sent = 1'b1;
            @(negedge clk);
            resp_sent = 1'b0;
        end
        wait_sig(1'b0);
        chk("dump_clr", 32'(clr_cmd_rdy), 32'd1);
        chk("dump_busy_end", 32'(dump_busy), 32'd0);
        cmd_rdy = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (clr_cmd_rdy || send_resp) extra++;
        end
        chk("dump_extra", 32'(extra), 32'd0);
    endtask

    initial begin
        logic [15:0] c;
        int op;
        for (int i = 0; i < ENTRIES; i++) ram[i] = NUM_CH*8'($urandom) ^ {$urandom, $urandom};
        build_map();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_send", 32'(send_resp), 32'd0);
        chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        check_regs("reset");

        for (int a = 0; a < 32; a++) apply(16'(a << 8), 1'b0);

        apply(16'h4755, 1'b0);
        check_regs("wr_vih");
        apply(16'h0700, 1'b0);

        do_dump(2, 380, -1);
        apply(16'h8700, 1'b0);
        apply(16'hC000, 1'b0);
        check_regs("op11");

        apply(16'h4001, 1'b1);
        chk("scd_write_wins", 32'(TrigCfg), 32'h01);
        @(negedge clk); set_capture_done = 1'b1;
        @(negedge clk); set_capture_done = 1'b0;
        mdl[0] = mdl[0] | 8'h10;
        chk("scd_alone", 32'(TrigCfg), 32'h11);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            if (op == 2) op = 1;
            c = {2'(op), 1'b0, 5'($urandom_range(0, 31)), 8'($urandom)};
            apply(c, 1'($urandom_range(0, 3) == 0));
            check_regs("rand");
        end

        do_dump($urandom_range(1, NUM_CH), $urandom_range(0, ENTRIES - 1), -1);
        do_dump(3, 10, 100);
        do_dump(NUM_CH, ENTRIES - 1, -1);
        check_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
